// File: rtl/msgdma_st_rr_arbiter_if.sv
// Shared streaming bus between the round-robin arbiter and its sources/sink.
// slave is the arbiter side; master is the sources, sink and debug side.
interface msgdma_st_rr_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 256
);
  logic [NUM_IN-1:0]        src_enable;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic [NUM_IN-1:0]        grant;
  logic                     busy;

  modport slave (
    input  src_enable, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, grant, busy
  );

  modport master (
    output src_enable, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, grant, busy
  );
endinterface

// File: rtl/msgdma_st_rr_arbiter.sv
// Round-robin arbiter feeding one registered beat stage; 1-cycle source-to-output latency.
// A held beat is never overwritten while out_ready is low; in_ready follows the stage's load.
module msgdma_st_rr_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  msgdma_st_rr_arbiter_if.slave   bus
);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q;
  logic [NUM_IN-1:0] grant_q;
  logic [IDX_W-1:0]  gidx_q;
  logic [IDX_W-1:0]  last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic              load;
  logic              xfer;
  logic              gnt_vld;
  logic [DATA_W-1:0] gnt_dat;
  logic [NUM_IN-1:0] eligible;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  int                sel_tmp;

  assign load     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = ((state_q == GRANT) && load) ? grant_q : '0;
  assign xfer     = |(bus.in_valid & bus.in_ready);
  assign gnt_vld  = |(bus.in_valid & grant_q);
  assign gnt_dat  = bus.in_data[gidx_q*DATA_W +: DATA_W];
  assign eligible = bus.in_valid & bus.src_enable;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == GRANT);

  // Search upward from the source after the last one served, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_tmp   = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      sel_tmp = int'(last_q) + k;
      if (sel_tmp >= NUM_IN) sel_tmp = sel_tmp - NUM_IN;
      if (!sel_found && eligible[IDX_W'(sel_tmp)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(sel_tmp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= IDX_W'(NUM_IN - 1);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (load) begin
        out_valid_q <= xfer;
        if (xfer) out_data_q <= gnt_dat;
      end
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q <= {{(NUM_IN-1){1'b0}}, 1'b1} << sel_idx;
            gidx_q  <= sel_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // Burst exhausted or source drained: a single release either way.
          if ((xfer && (cnt_q + 1'b1 == CNT_W'(MAX_BURST))) || !gnt_vld) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/msgdma_st_rr_arbiter.md
Name: msgdma_st_rr_arbiter

Overview:
- Round-robin arbiter that shares one 256-bit Avalon-ST datapath, the input of the mSGDMA streaming timing adapter, between NUM_IN requesting sources.
- Grants one source at a time for a bounded burst of beats.
- Forwards that source's beats through a single registered output stage.
- Exposes the current grant for debug and for the DMA status CSRs.

Parameters:
- NUM_IN, 4, number of requesting sources (2..8)
- DATA_W, 256, beat width in bits
- MAX_BURST, 8, maximum beats per grant (1..255)
- CNT_W, 8, width of the burst counter; must be able to hold MAX_BURST

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- src_enable  in  NUM_IN  per-source enable mask; a 0 bit excludes that source from new grants
- in_valid  in  NUM_IN  per-source valid
- in_data  in  NUM_IN*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W]
- in_ready  out  NUM_IN  per-source ready
- out_valid  out  1  registered valid toward the timing adapter
- out_data  out  DATA_W  registered data
- out_ready  in  1  downstream ready (timing adapter fill-level ready)
- grant  out  NUM_IN  one-hot current grant; all zero when idle
- busy  out  1  high while in GRANT state

Behaviour:
- Reset (reset_n sampled low at a clk edge):
  - out_valid=0, out_data=0, grant=0, busy=0, in_ready=0.
  - State goes to IDLE, burst counter to 0, last-served pointer to NUM_IN-1, so source 0 has first priority.
  - Reset mid-burst drops any beat held in the output register; no partial-state recovery.
- Output stage:
  - Single register holding one beat.
  - load = (!out_valid || out_ready); a register holding a beat is never overwritten while out_ready=0.
  - Source-to-output latency: 1 cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
- in_ready[i] = (state==GRANT) && grant[i] && load. Combinational; depends on out_ready. All other bits are 0.
- Beat transfer: a beat from source i transfers when in_valid[i] && in_ready[i]. out_valid is then set and out_data captures that source's slice.
- When out_ready=1 and no transfer occurs, out_valid clears.
- State IDLE:
  - eligible = in_valid & src_enable.
  - If eligible is nonzero, select the first set bit searching upward from (last+1) mod NUM_IN, with wrap-around.
  - Register grant to that one-hot value and move to GRANT. The arbitration bubble is 1 cycle.
  - No in_ready is asserted while in IDLE.
- State GRANT:
  - The counter increments on each transfer.
  - Go to IDLE, with grant=0, last=granted index and counter=0, when either:
    - a transfer occurs and counter+1==MAX_BURST, or
    - the granted source's in_valid=0 at a clk edge (source has nothing left to send).
  - When both conditions are true on the same edge, the result is one release, not two.
  - Clearing src_enable for the granted source mid-burst does not revoke the grant; it only blocks future grants.
  - With MAX_BURST=1, every grant carries exactly one beat.
- Fairness:
  - A source that was just served is lowest priority at the next arbitration.
  - With every source continuously valid, the grant order is 0,1,2,3,0,...
- Simultaneous events: out_ready=1 together with a transfer means pass-through. The old beat leaves and the new beat loads on the same edge, giving full throughput within a burst.
- busy = (state==GRANT).

Test Plan:
1. All 4 sources valid continuously, MAX_BURST=8, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001. Each grant carries 8 consecutive beats. A 1-cycle gap with out_valid=0 appears between bursts. Per-source beat order is preserved.
2. Only source 2 valid, 3 beats, then in_valid drops -> grant=0100 for the 3 transfers. The arbiter returns to IDLE on the first edge with in_valid[2]=0. out_data matches the source-2 payloads with 1-cycle latency.
3. out_ready toggles 1,0,0,1 during a burst -> out_data is held during out_ready=0 and in_ready[granted]=0 on those cycles. No beat is lost or duplicated; 8 beats are delivered in total.
4. src_enable=4'b1011 with all sources valid -> source 2 is never granted; the grant order is 0,1,3,0. Clearing bit 1 during source 1's burst lets that burst finish its 8 beats.
5. reset_n asserted low for 1 cycle in the middle of a burst (beat 5 of 8) -> the next cycle shows out_valid=0, grant=0 and busy=0. After release, source 0 wins first if it is valid.
6. MAX_BURST=1, sources 1 and 3 valid -> grants alternate 0010,1000 with exactly one beat each, and the counter never exceeds 1.
